// File: rtl/neuron_timebase_pkg.sv
// Shared definitions for the neuron time-base block: phase encodings,
// spike counter width and a saturating increment helper.
package neuron_timebase_pkg;

  localparam logic [1:0] PH_COUNT = 2'd0;
  localparam logic [1:0] PH_READ  = 2'd1;
  localparam logic [1:0] PH_IDLE  = 2'd2;
  localparam logic [1:0] PH_WRITE = 2'd3;

  localparam int unsigned SPIKE_CNT_W = 32;

  typedef logic [SPIKE_CNT_W-1:0] spike_cnt_t;

  localparam spike_cnt_t SPIKE_CNT_MAX = '1;

  // Increment by one when en is set, holding at all-ones.
  function automatic spike_cnt_t sat_inc(input spike_cnt_t v, input logic en);
    return (en && (v != SPIKE_CNT_MAX)) ? v + spike_cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/neuron_timebase_if.sv
// Control/status bundle of the neuron time-base.
// master: drives run, div_load, div_max_in, spike_in; observes the timing outputs.
// slave : the time-base itself.
interface neuron_timebase_if #(
  parameter int unsigned NN    = 8,
  parameter int unsigned DIV_W = 18
);
  import neuron_timebase_pkg::*;

  logic             run;
  logic             div_load;
  logic [DIV_W-1:0] div_max_in;
  logic             spike_in;

  logic             tick;
  logic             test_clk;
  logic [1:0]       phase;
  logic [NN-1:0]    neuron_index;
  logic             read_en;
  logic             write_en;
  logic             sim_tick;
  logic             spindle_tick;
  spike_cnt_t       spike_count_out;
  logic             spike_count_valid;

  modport master (
    output run, div_load, div_max_in, spike_in,
    input  tick, test_clk, phase, neuron_index, read_en, write_en,
           sim_tick, spindle_tick, spike_count_out, spike_count_valid
  );

  modport slave (
    input  run, div_load, div_max_in, spike_in,
    output tick, test_clk, phase, neuron_index, read_en, write_en,
           sim_tick, spindle_tick, spike_count_out, spike_count_valid
  );

endinterface

// File: rtl/neuron_timebase_tick_divider.sv
// Programmable clock divider producing a one-cycle tick every div_max+1
// running cycles.
// Ports: clk1, reset_global (async, active-high), run (count enable),
//        div_load/div_max_in (terminal count update), tick (registered pulse).
module tick_divider
  import neuron_timebase_pkg::*;
#(
  parameter int unsigned DIV_W   = 18,
  parameter int unsigned DIV_RST = 49
) (
  input  logic             clk1,
  input  logic             reset_global,
  input  logic             run,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_max_in,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] max_q, max_d;
  logic             tick_d;

  // >= rather than == so a terminal count lowered below the current count
  // wraps on the next compare instead of running to 2^DIV_W.
  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    tick_d  = 1'b0;
    if (run) begin
      if (count_q >= max_q) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end
    if (div_load) max_d = div_max_in;
  end

  always_ff @(posedge clk1 or posedge reset_global) begin
    if (reset_global) begin
      count_q <= '0;
      max_q   <= DIV_W'(DIV_RST);
      tick    <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/neuron_timebase.sv
// Neuron time-base: divides clk1 into time-step ticks, sequences neurons
// through count/read/idle/write phases, flags frame and spindle strobes and
// counts spikes per frame.
// Ports: clk1, reset_global (async, active-high), bus (neuron_timebase_if.slave).
module neuron_timebase
  import neuron_timebase_pkg::*;
#(
  parameter int unsigned NN      = 8,
  parameter int unsigned DIV_W   = 18,
  parameter int unsigned DIV_RST = 49,
  parameter int unsigned NSTROBE = 3
) (
  input  logic               clk1,
  input  logic               reset_global,
  neuron_timebase_if.slave   bus
);

  localparam int unsigned SEQ_W       = NN + 2;
  localparam int unsigned STROBE_STEP = (2 ** NN) / NSTROBE;

  logic             tick;
  logic [SEQ_W-1:0] seq_q, seq_d, seq_inc;
  logic             test_clk_q, test_clk_d;
  logic             sim_q, sim_d;
  logic             spin_q, spin_d;
  logic             valid_q, valid_d;
  spike_cnt_t       spk_q, spk_d;
  spike_cnt_t       out_q, out_d;
  logic             strobe_c;

  tick_divider #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_tick_divider (
    .clk1         (clk1),
    .reset_global (reset_global),
    .run          (bus.run),
    .div_load     (bus.div_load),
    .div_max_in   (bus.div_max_in),
    .tick         (tick)
  );

  assign seq_inc = seq_q + SEQ_W'(1);

  // Does the neuron index seq is about to reach sit on a strobe multiple?
  always_comb begin
    strobe_c = 1'b0;
    for (int unsigned k = 0; k < NSTROBE; k++) begin
      if (seq_inc[SEQ_W-1:2] == NN'(k * STROBE_STEP)) strobe_c = 1'b1;
    end
  end

  // Everything below advances only on a tick, so run low freezes it.
  always_comb begin
    seq_d      = seq_q;
    test_clk_d = test_clk_q;
    spk_d      = spk_q;
    out_d      = out_q;
    sim_d      = 1'b0;
    spin_d     = 1'b0;
    valid_d    = 1'b0;
    if (tick) begin
      seq_d      = seq_inc;
      test_clk_d = ~test_clk_q;
      sim_d      = (seq_inc == '0);
      spin_d     = (seq_inc[1:0] == PH_COUNT) && strobe_c;
      spk_d      = sat_inc(spk_q, (seq_q[1:0] == PH_WRITE) && bus.spike_in);
      // Frame wrap: publish the count including this tick's spike.
      if (seq_inc == '0) begin
        out_d   = spk_d;
        spk_d   = '0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or posedge reset_global) begin
    if (reset_global) begin
      seq_q      <= '0;
      test_clk_q <= 1'b0;
      sim_q      <= 1'b0;
      spin_q     <= 1'b0;
      valid_q    <= 1'b0;
      spk_q      <= '0;
      out_q      <= '0;
    end else begin
      seq_q      <= seq_d;
      test_clk_q <= test_clk_d;
      sim_q      <= sim_d;
      spin_q     <= spin_d;
      valid_q    <= valid_d;
      spk_q      <= spk_d;
      out_q      <= out_d;
    end
  end

  assign bus.tick              = tick;
  assign bus.test_clk          = test_clk_q;
  assign bus.phase             = seq_q[1:0];
  assign bus.neuron_index      = seq_q[SEQ_W-1:2];
  assign bus.read_en           = (seq_q[1:0] == PH_READ);
  assign bus.write_en          = (seq_q[1:0] == PH_WRITE);
  assign bus.sim_tick          = sim_q;
  assign bus.spindle_tick      = spin_q;
  assign bus.spike_count_out   = out_q;
  assign bus.spike_count_valid = valid_q;

endmodule
